seg7_display_driver: RTL and testbench

//  Downstream display stage of the RPN calculator. Takes the 16-bit top-of-stack value and a format select.

---
 rtl/seg7_pkg.sv | 40 ++++
 rtl/seg7_display_driver_if.sv | 20 ++
 rtl/bin_to_bcd.sv | 80 ++++++++
 rtl/seg7_display_driver.sv | 138 +++++++++++++
 tb/tb_seg7_display_driver.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the 7-segment display driver.
//   conv_state_t   : binary-to-BCD conversion FSM states
//   FMT_HEX/FMT_DEC: Format input encodings
//   SEG_BLANK      : all segments off (active low)
//   BCD_DIGITS/W   : decimal digits held by the converter (enough for 16-bit values)
//   hex_to_seg()   : nibble -> active-low {CA..CG} segment code
package seg7_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} conv_state_t;

    localparam logic       FMT_HEX    = 1'b0;
    localparam logic       FMT_DEC    = 1'b1;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam int         BCD_DIGITS = 5;
    localparam int         BCD_W      = 4 * BCD_DIGITS;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h01;
            4'h1: s = 7'h4F;
            4'h2: s = 7'h12;
            4'h3: s = 7'h06;
            4'h4: s = 7'h4C;
            4'h5: s = 7'h24;
            4'h6: s = 7'h20;
            4'h7: s = 7'h0F;
            4'h8: s = 7'h00;
            4'h9: s = 7'h04;
            4'hA: s = 7'h08;
            4'hB: s = 7'h60;
            4'hC: s = 7'h31;
            4'hD: s = 7'h42;
            4'hE: s = 7'h30;
            default: s = 7'h38;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_display_driver_if.sv
// seg7_display_driver_if: value/format in, segment/anode/busy out.
//   Value    : binary value to display
//   Format   : 0 = hex, 1 = unsigned decimal
//   Segments : {CA..CG}, active low, bit6 = CA
//   Anodes   : active low, bit0 = rightmost digit
//   Busy     : binary-to-BCD conversion in flight
// master = the value producer, slave = the display driver.
interface seg7_display_driver_if #(
    parameter int DATA_W   = 16,
    parameter int N_DIGITS = 8
);
    logic [DATA_W-1:0]   Value;
    logic                Format;
    logic [6:0]          Segments;
    logic [N_DIGITS-1:0] Anodes;
    logic                Busy;

    modport master (output Value, Format, input Segments, Anodes, Busy);
    modport slave  (input Value, Format, output Segments, Anodes, Busy);
endinterface

// File: rtl/bin_to_bcd.sv
// bin_to_bcd: sequential double-dabble converter.
//   clk, resetN : clock, async active-low reset
//   start       : request a conversion (acted on only in IDLE)
//   bin         : binary input, latched in LOAD
//   busy        : high from IDLE->LOAD until COMMIT->IDLE
//   done        : high for the single COMMIT cycle, when bcd updates
//   bcd         : last committed result, 5 BCD nibbles
// Timing: start seen -> LOAD -> DATA_W x SHIFT -> COMMIT, so bcd is
// written DATA_W+2 edges after the edge that sampled start.
module bin_to_bcd
    import seg7_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              start,
    input  logic [DATA_W-1:0] bin,
    output logic              busy,
    output logic              done,
    output logic [BCD_W-1:0]  bcd
);
    localparam int SH_W  = BCD_W + DATA_W;
    localparam int CNT_W = $clog2(DATA_W) + 1;

    conv_state_t      state;
    logic [SH_W-1:0]  sh;
    logic [SH_W-1:0]  sh_adj;
    logic [CNT_W-1:0] cnt;

    // Add-3 correction on every BCD nibble >= 5 before the shift.
    always_comb begin
        sh_adj = sh;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (sh[DATA_W + 4*i +: 4] >= 4'd5)
                sh_adj[DATA_W + 4*i +: 4] = sh[DATA_W + 4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
            sh    <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            bcd   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    sh    <= {{BCD_W{1'b0}}, bin};
                    cnt   <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    sh  <= sh_adj << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        state <= COMMIT;
                        done  <= 1'b1;   // registered so it is high exactly in COMMIT
                    end
                end
                COMMIT: begin
                    bcd   <= sh[SH_W-1 -: BCD_W];
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/seg7_display_driver.sv
// seg7_display_driver: display stage of the RPN calculator.
//   clk, resetN : clock, async active-low reset
//   bus (slave) : Value/Format in; Segments/Anodes/Busy out
// Keeps a committed snapshot (hex source) and its BCD (decimal source)
// so the scan never shows a half-updated value. Each digit is lit for
// REFRESH_CYCLES clocks; Segments/Anodes are registered one cycle behind
// the scan index.
// Build option: define LEADING_ZERO_BLANK_EN to blank digits above the
// most significant nonzero digit (digit 0 always shown).
module seg7_display_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_CYCLES = 100_000,
    parameter int N_DIGITS       = 8,
    parameter int DATA_W         = 16
) (
    input  logic                 clk,
    input  logic                 resetN,
    seg7_display_driver_if.slave bus
);
    localparam int RC_W       = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int IDX_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int HEX_DIGITS = (DATA_W + 3) / 4;
    localparam int MAX_A      = (N_DIGITS > HEX_DIGITS) ? N_DIGITS : HEX_DIGITS;
    localparam int VEC_DIGITS = (MAX_A > BCD_DIGITS) ? MAX_A : BCD_DIGITS;
    localparam int VEC_W      = 4 * VEC_DIGITS;

    // ---------------- change detect / snapshot ----------------
    logic [DATA_W-1:0] snapshot;
    logic [DATA_W-1:0] cap_q;
    logic              first_q;
    logic              busy_d;
    logic              start;
    logic              load_cyc;
    logic              conv_busy;
    logic              conv_done;
    logic [BCD_W-1:0]  bcd_q;

    assign start    = first_q | (bus.Value != snapshot);
    // busy rises on the edge into LOAD; the cycle it first reads high is
    // LOAD, the same cycle the converter latches Value.
    assign load_cyc = conv_busy & ~busy_d;

    bin_to_bcd #(.DATA_W(DATA_W)) u_conv (
        .clk    (clk),
        .resetN (resetN),
        .start  (start),
        .bin    (bus.Value),
        .busy   (conv_busy),
        .done   (conv_done),
        .bcd    (bcd_q)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            snapshot <= '0;
            cap_q    <= '0;
            first_q  <= 1'b1;
            busy_d   <= 1'b0;
        end else begin
            first_q <= 1'b0;
            busy_d  <= conv_busy;
            if (load_cyc)  cap_q    <= bus.Value;
            // Same edge the converter writes bcd: both sources switch together.
            if (conv_done) snapshot <= cap_q;
        end
    end

    // ---------------- scan ----------------
    logic [RC_W-1:0]  refresh_cnt;
    logic [IDX_W-1:0] scan_idx;
    logic             fmt_q;
    logic             wrap;

    assign wrap = (refresh_cnt == RC_W'(REFRESH_CYCLES - 1));

    // Format is sampled at slot boundaries so a slot never changes
    // representation halfway through.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            refresh_cnt <= '0;
            scan_idx    <= '0;
            fmt_q       <= FMT_HEX;
        end else if (wrap) begin
            refresh_cnt <= '0;
            scan_idx    <= (scan_idx == IDX_W'(N_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
            fmt_q       <= bus.Format;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // ---------------- digit mux / blanking ----------------
    logic [VEC_W-1:0] src_vec;
    logic [3:0]       digit;
    logic             show;
    int               n_valid;

    always_comb begin
        src_vec = '0;
        n_valid = HEX_DIGITS;
        if (fmt_q == FMT_DEC) begin
            src_vec[BCD_W-1:0] = bcd_q;
            n_valid            = BCD_DIGITS;
        end else begin
            src_vec[DATA_W-1:0] = snapshot;
        end
        digit = src_vec[{scan_idx, 2'b00} +: 4];
        show  = (int'(scan_idx) < n_valid);
`ifdef LEADING_ZERO_BLANK_EN
        // Nothing nonzero at or above this position -> leading zero.
        if (scan_idx != '0 && (src_vec >> {scan_idx, 2'b00}) == '0)
            show = 1'b0;
`endif
    end

    // ---------------- output registers ----------------
    logic [6:0]          seg_q;
    logic [N_DIGITS-1:0] an_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            seg_q <= SEG_BLANK;
            an_q  <= '1;
        end else if (show) begin
            seg_q <= hex_to_seg(digit);
            an_q  <= ~(N_DIGITS'(1) << scan_idx);
        end else begin
            seg_q <= SEG_BLANK;
            an_q  <= '1;
        end
    end

    assign bus.Segments = seg_q;
    assign bus.Anodes   = an_q;
    assign bus.Busy     = conv_busy;

endmodule

// File: tb/tb_seg7_display_driver.sv
module tb_seg7_display_driver;

    logic clk = 1'b0;
    logic resetN;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    seg7_display_driver_if #(.DATA_W(16), .N_DIGITS(8)) bus ();

    seg7_display_driver #(.REFRESH_CYCLES(4), .N_DIGITS(8), .DATA_W(16)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    // Vector record: inputs plus expected 8-char display text, leftmost
    // char = AN7, ' ' = dark digit. pad = zero-padded build, lzb = blanking build.
    typedef struct {
        logic [15:0] value;
        logic        fmt;
        string       pad;
        string       lzb;
    } vec_t;

    vec_t  vecs[12];
    string exp_q[$];

    function automatic vec_t mk(input logic [15:0] v, input logic f, input string p, input string l);
        vec_t r;
        r.value = v; r.fmt = f; r.pad = p; r.lzb = l;
        return r;
    endfunction

    function automatic string pick(input string p, input string l);
`ifdef LEADING_ZERO_BLANK_EN
        return l;
`else
        return p;
`endif
    endfunction

    function automatic logic [6:0] char2seg(input byte c);
        case (c)
            "0": return 7'h01;  "1": return 7'h4F;  "2": return 7'h12;  "3": return 7'h06;
            "4": return 7'h4C;  "5": return 7'h24;  "6": return 7'h20;  "7": return 7'h0F;
            "8": return 7'h00;  "9": return 7'h04;  "A": return 7'h08;  "B": return 7'h60;
            "C": return 7'h31;  "D": return 7'h42;  "E": return 7'h30;  "F": return 7'h38;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Wait for any conversion to finish, then for Format to latch at a slot edge.
    task automatic settle(input string nm);
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while (bus.Busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " settle"}, 32'(bus.Busy), 32'd0);
        repeat (6) @(negedge clk);
    endtask

    // Counts Busy-high cycles and low gaps until Busy stays low 3 cycles.
    task automatic count_busy(input string nm, input int exp_hi, input int exp_gaps);
        int hi, gaps, lowrun, n;
        bit started;
        hi = 0; gaps = 0; lowrun = 0; n = 0; started = 1'b0;
        while (!started && n < 5) begin
            @(negedge clk);
            n++;
            if (bus.Busy) begin
                started = 1'b1;
                hi      = 1;
            end
        end
        while (started && lowrun < 3 && n < 300) begin
            @(negedge clk);
            n++;
            if (bus.Busy) begin
                if (lowrun > 0) gaps++;
                lowrun = 0;
                hi++;
            end else begin
                lowrun++;
            end
        end
        chk({nm, " busy rise"},   32'(started), 32'd1);
        chk({nm, " busy end"},    32'(lowrun >= 3), 32'd1);
        chk({nm, " busy cycles"}, 32'(hi), 32'(exp_hi));
        chk({nm, " busy gaps"},   32'(gaps), 32'(exp_gaps));
    endtask

    // Watches a full scan and compares what each anode showed.
    task automatic observe(input string nm, input string exp_txt, output int busy_hits);
        logic [6:0] seen [8];
        bit         lit  [8];
        int         illegal;
        byte        c;
        illegal   = 0;
        busy_hits = 0;
        for (int k = 0; k < 8; k++) begin
            lit[k]  = 1'b0;
            seen[k] = 7'h7F;
        end
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (bus.Busy) busy_hits++;
            if (bus.Anodes == 8'hFF) begin
                if (bus.Segments != 7'h7F) illegal++;
            end else if ($countones(~bus.Anodes) == 1) begin
                for (int k = 0; k < 8; k++) begin
                    if (!bus.Anodes[k]) begin
                        if (lit[k] && seen[k] != bus.Segments) illegal++;
                        lit[k]  = 1'b1;
                        seen[k] = bus.Segments;
                    end
                end
            end else begin
                illegal++;
            end
        end
        chk({nm, " scan legality"}, 32'(illegal), 32'd0);
        for (int k = 0; k < 8; k++) begin
            c = exp_txt[7-k];
            if (c == " ") begin
                chk($sformatf("%s AN%0d dark", nm, k), 32'(lit[k]), 32'd0);
            end else begin
                chk($sformatf("%s AN%0d lit", nm, k), 32'(lit[k]), 32'd1);
                chk($sformatf("%s AN%0d seg", nm, k), 32'(seen[k]), 32'(char2seg(c)));
            end
        end
    endtask

    initial begin
        int bh;
        vecs[0]  = mk(16'h0000, 1'b0, "    0000", "       0");
        vecs[1]  = mk(16'h0000, 1'b1, "   00000", "       0");
        vecs[2]  = mk(16'h0007, 1'b1, "   00007", "       7");
        vecs[3]  = mk(16'h0007, 1'b0, "    0007", "       7");
        vecs[4]  = mk(16'hA0B0, 1'b0, "    A0B0", "    A0B0");
        vecs[5]  = mk(16'd10000, 1'b1, "   10000", "   10000");
        vecs[6]  = mk(16'h000C, 1'b0, "    000C", "       C");
        vecs[7]  = mk(16'd4096, 1'b1, "   04096", "    4096");
        vecs[8]  = mk(16'h0F00, 1'b0, "    0F00", "     F00");
        vecs[9]  = mk(16'd99,   1'b1, "   00099", "      99");
        vecs[10] = mk(16'hFFFF, 1'b1, "   65535", "   65535");
        vecs[11] = mk(16'h5A3C, 1'b0, "    5A3C", "    5A3C");

        resetN     = 1'b0;
        bus.Value  = 16'h0000;
        bus.Format = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset seg",  32'(bus.Segments), 32'h7F);
        chk("reset an",   32'(bus.Anodes),   32'hFF);
        chk("reset busy", 32'(bus.Busy),     32'd0);

        // First cycle after reset converts even though Value == snapshot.
        resetN = 1'b1;
        exp_q.push_back(pick("    0000", "       0"));
        count_busy("post-reset", 18, 0);
        settle("post-reset");
        observe("zero", exp_q.pop_front(), bh);

        // Hex 1234, 18-cycle busy window.
        bus.Value = 16'h1234;
        exp_q.push_back("    1234");
        count_busy("h1234", 18, 0);
        settle("h1234");
        observe("h1234", exp_q.pop_front(), bh);

        // Async reset mid-run, no clock edge in between.
        @(negedge clk);
        resetN = 1'b0;
        #1;
        chk("async rst seg",  32'(bus.Segments), 32'h7F);
        chk("async rst an",   32'(bus.Anodes),   32'hFF);
        chk("async rst busy", 32'(bus.Busy),     32'd0);
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        exp_q.push_back("    1234");
        count_busy("rst-idle", 18, 0);
        settle("rst-idle");
        observe("rst-idle", exp_q.pop_front(), bh);

        // 65535 decimal, then Format-only change must not reconvert.
        bus.Value  = 16'hFFFF;
        bus.Format = 1'b1;
        exp_q.push_back("   65535");
        count_busy("d65535", 18, 0);
        settle("d65535");
        observe("d65535", exp_q.pop_front(), bh);
        bus.Format = 1'b0;
        exp_q.push_back("    FFFF");
        settle("fmt toggle");
        observe("fmt toggle", exp_q.pop_front(), bh);
        chk("fmt toggle busy", 32'(bh), 32'd0);

        // Value changes mid-conversion: finish, commit, reconvert.
        bus.Format = 1'b1;
        bus.Value  = 16'h0001;
        exp_q.push_back(pick("   00255", "     255"));
        fork
            count_busy("back2back", 36, 1);
            begin
                repeat (5) @(negedge clk);
                bus.Value = 16'h00FF;
            end
        join
        settle("back2back");
        observe("back2back", exp_q.pop_front(), bh);

        // Reset during SHIFT aborts; release reconverts the current Value.
        bus.Format = 1'b0;
        bus.Value  = 16'hBEEF;
        repeat (8) @(negedge clk);
        chk("shift in flight", 32'(bus.Busy), 32'd1);
        resetN = 1'b0;
        #1;
        chk("shift rst busy", 32'(bus.Busy),     32'd0);
        chk("shift rst an",   32'(bus.Anodes),   32'hFF);
        chk("shift rst seg",  32'(bus.Segments), 32'h7F);
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        exp_q.push_back("    BEEF");
        count_busy("shift rst", 18, 0);
        settle("shift rst");
        observe("shift rst", exp_q.pop_front(), bh);

        // Table-driven vectors.
        for (int i = 0; i < 12; i++) begin
            bus.Value  = vecs[i].value;
            bus.Format = vecs[i].fmt;
            exp_q.push_back(pick(vecs[i].pad, vecs[i].lzb));
            settle($sformatf("vec%0d", i));
            observe($sformatf("vec%0d", i), exp_q.pop_front(), bh);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
